// File: rtl/dom_and_sched.sv
// Round-robin sequencer sharing one registered 2-share DOM-independent AND gadget
// between N_REQ requesters; every share-carrying register is wiped between operations.
module dom_and_sched #(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_ax,
    input  logic [N_REQ*W-1:0] req_bx,
    input  logic [N_REQ*W-1:0] req_ay,
    input  logic [N_REQ*W-1:0] req_by,
    input  logic               rnd_valid,
    output logic               rnd_ready,
    input  logic [W-1:0]       rnd_data,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [IDW-1:0]     resp_id,
    output logic [W-1:0]       resp_aq,
    output logic [W-1:0]       resp_bq
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RND  = 3'd1,
        S_MUL  = 3'd2,
        S_COMP = 3'd3,
        S_RESP = 3'd4,
        S_CLR  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   ax_q, ax_d, bx_q, bx_d, ay_q, ay_d, by_q, by_d, z_q, z_d;
    logic [W-1:0]   t0_q, t0_d, t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
    logic [W-1:0]   aq_q, aq_d, bq_q, bq_d;
    logic           grant_found_s;
    logic [IDW-1:0] grant_idx_s;
    logic [IDW-1:0] cand_s;
    logic           wipe_s;

    // Round-robin search starting just after the previous winner, with wrap.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = rr_ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (cand_s == IDW'(N_REQ - 1)) begin
                cand_s = '0;
            end else begin
                cand_s = cand_s + 1'b1;
            end
            if (!grant_found_s && req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Sequencer next-state, datapath and handshake outputs.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        ax_d       = ax_q;
        bx_d       = bx_q;
        ay_d       = ay_q;
        by_d       = by_q;
        z_d        = z_q;
        t0_d       = t0_q;
        t1_d       = t1_q;
        t2_d       = t2_q;
        t3_d       = t3_q;
        aq_d       = aq_q;
        bq_d       = bq_q;
        wipe_s     = 1'b0;
        req_ready  = '0;
        rnd_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Only the winner's slot is routed into the operand registers.
                if (rst_n && grant_found_s) begin
                    req_ready[grant_idx_s] = 1'b1;
                    ax_d     = req_ax[grant_idx_s*W +: W];
                    bx_d     = req_bx[grant_idx_s*W +: W];
                    ay_d     = req_ay[grant_idx_s*W +: W];
                    by_d     = req_by[grant_idx_s*W +: W];
                    id_d     = grant_idx_s;
                    rr_ptr_d = grant_idx_s;
                    state_d  = S_RND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RND: begin
                rnd_ready = 1'b1;
                if (rnd_valid) begin
                    z_d     = rnd_data;
                    state_d = S_MUL;
                end else begin
                    state_d = S_RND;
                end
            end
            S_MUL: begin
                // Cross terms are refreshed with Z before they are ever combined.
                t0_d    = ax_q & ay_q;
                t1_d    = (ax_q & by_q) ^ z_q;
                t2_d    = (bx_q & ay_q) ^ z_q;
                t3_d    = bx_q & by_q;
                state_d = S_COMP;
            end
            S_COMP: begin
                aq_d    = t0_q ^ t1_q;
                bq_d    = t2_q ^ t3_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    wipe_s  = 1'b1;
                    state_d = S_CLR;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_CLR: begin
                wipe_s  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                wipe_s  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        // Zeroing on entry to CLR keeps the share registers at 0 for that whole cycle.
        if (wipe_s) begin
            ax_d = '0;
            bx_d = '0;
            ay_d = '0;
            by_d = '0;
            z_d  = '0;
            t0_d = '0;
            t1_d = '0;
            t2_d = '0;
            t3_d = '0;
            aq_d = '0;
            bq_d = '0;
        end else begin
            wipe_s = 1'b0;
        end
    end

    // State, pointer and share registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= IDW'(N_REQ - 1);
            id_q     <= '0;
            ax_q     <= '0;
            bx_q     <= '0;
            ay_q     <= '0;
            by_q     <= '0;
            z_q      <= '0;
            t0_q     <= '0;
            t1_q     <= '0;
            t2_q     <= '0;
            t3_q     <= '0;
            aq_q     <= '0;
            bq_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            ax_q     <= ax_d;
            bx_q     <= bx_d;
            ay_q     <= ay_d;
            by_q     <= by_d;
            z_q      <= z_d;
            t0_q     <= t0_d;
            t1_q     <= t1_d;
            t2_q     <= t2_d;
            t3_q     <= t3_d;
            aq_q     <= aq_d;
            bq_q     <= bq_d;
        end
    end

    assign resp_id = id_q;
    assign resp_aq = aq_q;
    assign resp_bq = bq_q;

endmodule

// File: tb/tb_dom_and_sched.sv
// Randomized scoreboard bench for dom_and_sched: an abstract arbitration/timing model
// predicts grants and handshakes, and a monitor checks every response against it.
module tb_dom_and_sched;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_ax, req_bx, req_ay, req_by;
    logic           rnd_valid;
    logic           rnd_ready;
    logic [W-1:0]   rnd_data;
    logic           resp_valid;
    logic           resp_ready;
    logic [IDW-1:0] resp_id;
    logic [W-1:0]   resp_aq, resp_bq;

    dom_and_sched #(.N_REQ(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ax(req_ax), .req_bx(req_bx), .req_ay(req_ay), .req_by(req_by),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_aq(resp_aq), .resp_bq(resp_bq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [W-1:0] aq;
        logic [W-1:0] bq;
        logic [W-1:0] prod;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail = 0;
    int n_grant = 0;
    int n_resp = 0;
    int drv_timeouts = 0;

    logic         data_rand = 1'b1;
    logic         rq_rand = 1'b0;
    logic         chk_period = 1'b0;
    logic [N-1:0] rq_fixed = '0;
    int           rnd_pct = 100;
    int           resp_pct = 100;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // First requesting slot after the last winner, wrapping around.
    function automatic int pick(input logic [N-1:0] v, input int rr);
        int r;
        r = -1;
        for (int k = 1; k <= N; k++) begin
            if (r < 0 && v[(rr + k) % N]) r = (rr + k) % N;
        end
        return r;
    endfunction

    int           m_rr = N - 1;
    int           m_cnt = 0;
    int           m_stall = 0;
    int           cyc = 0;
    int           last_gcyc = -1;
    int           seen_to = 0;
    bit           m_busy = 1'b0;
    bit           m_have_z = 1'b0;
    bit           m_clr = 1'b0;
    bit           rst_low = 1'b0;
    int           p_id = 0;
    logic [W-1:0] p_ax, p_bx, p_ay, p_by;

    // Monitor: reference model of grant/timing plus scoreboard comparison.
    always @(negedge clk) begin : monitor
        logic [N-1:0] exp_rr;
        logic         exp_rnd;
        logic         exp_rv;
        int           w;
        logic [W-1:0] y;
        exp_t         e;
        cyc++;
        check("wait_bound", 32'(drv_timeouts), 32'(seen_to));
        seen_to = drv_timeouts;
        if (!rst_n) begin
            if (rst_low) begin
                check("rst_req_ready", 32'(req_ready), 32'd0);
                check("rst_rnd_ready", 32'(rnd_ready), 32'd0);
                check("rst_resp_valid", 32'(resp_valid), 32'd0);
                check("rst_resp_id", 32'(resp_id), 32'd0);
                check("rst_resp_aq", 32'(resp_aq), 32'd0);
                check("rst_resp_bq", 32'(resp_bq), 32'd0);
            end
            rst_low   = 1'b1;
            m_busy    = 1'b0;
            m_have_z  = 1'b0;
            m_clr     = 1'b0;
            m_rr      = N - 1;
            last_gcyc = -1;
            exp_q.delete();
        end else begin
            rst_low = 1'b0;
            if (m_busy) m_cnt++;
            exp_rr = '0;
            w = -1;
            if (!m_busy && (req_valid != '0)) begin
                w = pick(req_valid, m_rr);
                exp_rr = {{(N-1){1'b0}}, 1'b1} << w;
            end
            exp_rnd = m_busy && !m_have_z;
            exp_rv  = m_busy && m_have_z && !m_clr && (m_cnt >= 4 + m_stall);
            check("req_ready", 32'(req_ready), 32'(exp_rr));
            check("rnd_ready", 32'(rnd_ready), 32'(exp_rnd));
            check("resp_valid", 32'(resp_valid), 32'(exp_rv));
            if (exp_rv) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q[0];
                    check("resp_id", 32'(resp_id), 32'(e.id));
                    check("resp_aq", 32'(resp_aq), 32'(e.aq));
                    check("resp_bq", 32'(resp_bq), 32'(e.bq));
                    check("unmasked_and", 32'(resp_aq ^ resp_bq), 32'(e.prod));
                end
                if (resp_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    n_resp++;
                    m_clr = 1'b1;
                end
            end else if (w >= 0) begin
                m_busy   = 1'b1;
                m_rr     = w;
                m_cnt    = 0;
                m_stall  = 0;
                m_have_z = 1'b0;
                n_grant++;
                p_id = w;
                p_ax = req_ax[w*W +: W];
                p_bx = req_bx[w*W +: W];
                p_ay = req_ay[w*W +: W];
                p_by = req_by[w*W +: W];
                if (chk_period) begin
                    if (last_gcyc >= 0) check("grant_period", 32'(cyc - last_gcyc), 32'd6);
                    last_gcyc = cyc;
                end
            end else if (m_busy && m_clr) begin
                check("clr_aq", 32'(resp_aq), 32'd0);
                check("clr_bq", 32'(resp_bq), 32'd0);
                m_busy = 1'b0;
                m_clr  = 1'b0;
            end else if (exp_rnd) begin
                if (rnd_valid) begin
                    y      = p_ay ^ p_by;
                    e.id   = p_id;
                    e.aq   = (p_ax & y) ^ rnd_data;
                    e.bq   = (p_bx & y) ^ rnd_data;
                    e.prod = (p_ax ^ p_bx) & y;
                    exp_q.push_back(e);
                    m_have_z = 1'b1;
                end else begin
                    m_stall++;
                end
            end
            if (!chk_period) last_gcyc = -1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (data_rand) begin
            for (int i = 0; i < N; i++) begin
                req_ax[i*W +: W] = W'($urandom);
                req_bx[i*W +: W] = W'($urandom);
                req_ay[i*W +: W] = W'($urandom);
                req_by[i*W +: W] = W'($urandom);
            end
            rnd_data = W'($urandom);
        end
        req_valid  = rq_rand ? N'($urandom) : rq_fixed;
        rnd_valid  = ($urandom_range(99, 0) < rnd_pct);
        resp_ready = ($urandom_range(99, 0) < resp_pct);
    endtask

    task automatic wait_grant();
        int g0;
        g0 = n_grant;
        for (int k = 0; k < 40 && n_grant == g0; k++) step();
        if (n_grant == g0) drv_timeouts++;
    endtask

    initial begin : driver
        int tgt;
        rst_n = 1'b0; req_valid = '0; rnd_valid = 1'b0; resp_ready = 1'b0; rnd_data = '0;
        req_ax = '0; req_bx = '0; req_ay = '0; req_by = '0;
        repeat (3) step();

        // All requesters active from reset: grants 0,1,2,3,0 six cycles apart.
        rq_fixed = 4'b1111; chk_period = 1'b1;
        step();
        rst_n = 1'b1;
        repeat (25) step();
        chk_period = 1'b0; rq_fixed = '0;
        repeat (8) step();

        // Known-answer operation on slot 2.
        data_rand = 1'b0;
        req_ax[2*W +: W] = 8'hA5; req_bx[2*W +: W] = 8'h3C;
        req_ay[2*W +: W] = 8'h0F; req_by[2*W +: W] = 8'hF0;
        rnd_data = 8'h5A;
        rq_fixed = 4'b0100;
        wait_grant();
        rq_fixed = '0;
        repeat (10) step();
        data_rand = 1'b1;

        // Randomness held off for five cycles after the grant.
        rnd_pct = 0; rq_fixed = 4'b1000;
        wait_grant();
        rq_fixed = '0;
        repeat (5) step();
        rnd_pct = 100;
        repeat (12) step();

        // Consumer backpressure with other requests arriving meanwhile.
        resp_pct = 0; rq_rand = 1'b1;
        wait_grant();
        repeat (8) step();
        resp_pct = 100; rq_rand = 1'b0; rq_fixed = '0;
        repeat (12) step();

        // Reset while the gadget is in its multiply stage.
        rq_fixed = 4'b0001;
        wait_grant();
        rq_fixed = '0;
        step();
        rst_n = 1'b0; rq_fixed = 4'b1001; req_valid = 4'b1001;
        step();
        step();
        rst_n = 1'b1;
        step();
        rq_fixed = '0;
        repeat (12) step();

        // Random regression over 1000 operations.
        rq_rand = 1'b1; rnd_pct = 70; resp_pct = 70;
        tgt = n_resp + 1000;
        for (int k = 0; k < 30000 && n_resp < tgt; k++) step();
        if (n_resp < tgt) drv_timeouts++;
        rq_rand = 1'b0; rq_fixed = '0; rnd_pct = 100; resp_pct = 100;
        repeat (12) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dom_and_sched.md
Name: dom_and_sched

Overview:
- Sequencer/arbiter that shares one registered 2-share DOM-independent AND datapath between N_REQ requesters.
- Per operation: grants one requester round-robin, fetches fresh randomness Z from the on-chip randomness source, and runs the two-stage masked multiply (cross terms refreshed with Z, then compression).
- Returns the result shares, then zeroes all share-carrying registers for one cycle so consecutive operations cannot combine in transition leakage.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- W, 8, bit width of each share vector; bitwise AND over W lanes.
- IDW, $clog2(N_REQ), width of requester id.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  N_REQ  per-requester operation request.
- req_ready  out  N_REQ  one-hot accept strobe; at most one bit set.
- req_ax, req_bx  in  N_REQ*W  shares of x; slot i at bits [i*W +: W].
- req_ay, req_by  in  N_REQ*W  shares of y; same packing.
- rnd_valid  in  1  randomness available.
- rnd_ready  out  1  randomness consumed when rnd_valid & rnd_ready.
- rnd_data  in  W  fresh mask Z.
- resp_valid  out  1  result shares valid.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  IDW  requester the result belongs to.
- resp_aq, resp_bq  out  W  result shares; resp_aq ^ resp_bq = (ax^bx) & (ay^by).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; all operand, Z, stage and result registers = 0.
  - req_ready=0, rnd_ready=0, resp_valid=0, resp_id=0, resp_aq=resp_bq=0.
  - rr_ptr=N_REQ-1, so requester 0 has highest priority first.
  - Reset mid-operation abandons the operation silently; no response is ever issued for it.
- IDLE:
  - Winner g is the first requester with req_valid set, searching from (rr_ptr+1) mod N_REQ upward with wrap.
  - req_ready[g]=1 combinationally in the same cycle.
  - At the edge: latch the four shares of g and id=g; set rr_ptr=g; go to RND.
  - No request: stay in IDLE; req_ready=0.
- RND:
  - rnd_ready=1.
  - On rnd_valid: latch Z=rnd_data and go to MUL; otherwise wait indefinitely.
  - rnd_ready is 0 in every other state.
- MUL (1 cycle). Register:
  - t0=ax&ay
  - t1=(ax&by)^Z
  - t2=(bx&ay)^Z
  - t3=bx&by
  - Then go to COMP.
- COMP (1 cycle):
  - Register resp_aq=t0^t1 and resp_bq=t2^t3; drive resp_id=id.
  - Go to RESP.
- RESP:
  - resp_valid=1; data stable while waiting.
  - On resp_ready: go to CLR. Otherwise hold.
- CLR (1 cycle):
  - Zero the operand, Z, t0..t3 and resp_aq/resp_bq registers; resp_valid=0.
  - Go to IDLE. rr_ptr is retained.
- No share pair is ever combined in a single gate; only the like-share and Z-refreshed products listed above exist.
- Latency: with rnd_valid held high, resp_valid rises 3 cycles after the req accept edge. Each additional cycle of rnd_valid low adds one cycle.
- Minimum period: 6 cycles per operation (IDLE, RND, MUL, COMP, RESP, CLR) with rnd_valid and resp_ready high.
- Fairness: a continuously requesting requester waits at most N_REQ-1 operations.
- req_valid deasserting while not granted is legal and is simply ignored.
- The shares of non-winners are never sampled.

Test Plan:
- Single op, N_REQ=4, W=8, slot 2: ax=A5, bx=3C, ay=0F, by=F0, Z=5A, rnd_valid and resp_ready high.
  - req_ready=4'b0100 for one cycle; t0=05, t1=FA, t2=56, t3=30.
  - resp_aq=FF, resp_bq=66, resp_id=2; resp_valid 3 cycles after accept.
- Round robin: all req_valid high continuously from reset.
  - Grant order 0,1,2,3,0.
  - Successive req_ready pulses 6 cycles apart.
- Randomness stall: rnd_valid low for 5 cycles after grant.
  - FSM stays in RND; rnd_ready high throughout; resp_valid delayed 5 cycles.
  - Z sampled only on the handshake cycle.
- Backpressure: resp_ready low for 4 cycles.
  - resp_valid, resp_id and resp_aq/bq held stable; no new req_ready.
  - After acceptance, one CLR cycle with all share registers = 0.
- Reset mid-op: rst_n=0 during MUL.
  - Next cycle: all outputs 0, state IDLE.
  - A pending request from slot 3 with slot 0 also pending: slot 0 granted first.
- Random regression: 1000 ops with random shares and Z.
  - resp_aq^resp_bq == (ax^bx)&(ay^by) for every response.
  - resp_id matches the granted requester.
